dm_access_arbiter: RTL
======================

Name: dm_access_arbiter

Overview:
- Sequences and shares the single data-memory port between two requesters: the pipeline M stage and a secondary port (loader/debug bridge, "X").
- Models a multi-cycle memory: every access takes WAIT_CYCLES+1 cycles. The M stage is stalled until its access completes.
- Sits between the M-stage control/forwarding logic and dm_M.
- Drives dm_M's address, write data, write enable and LStype inputs, and returns read data to the requesters.

Parameters:
- WAIT_CYCLES, 2: wait states before the completing cycle. Legal range 0..15.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- M_Req  in  1  M stage holds a load or store this cycle
- M_WE  in  1  M-stage access is a store
- M_Addr  in  32  M-stage byte address (AOM)
- M_WD  in  32  M-stage store data, already forwarded
- M_LStype  in  3  M-stage access type (ctrl LStype encoding)
- M_RD  out  32  read data for M stage; valid in M's DONE cycle
- M_Stall  out  1  freeze PC/F/D/E/M registers and bubble W
- X_Req  in  1  secondary request; held until X_Done
- X_WE  in  1  secondary store
- X_Addr  in  32  secondary address, word access only
- X_WD  in  32  secondary store data
- X_Gnt  out  1  X currently owns the memory port
- X_Done  out  1  one-cycle completion pulse for X
- X_RD  out  32  registered X read data; holds until the next X read
- DM_Addr  out  32  to dm_M Addr
- DM_WD  out  32  to dm_M WD
- DM_WE  out  1  to dm_M WE
- DM_LStype  out  3  to dm_M LStype; forced to word type for X

Behaviour:
- Reset:
  - State returns to IDLE and the counter is cleared.
  - X_Gnt=0, X_Done=0, X_RD=0, DM_WE=0, M_Stall=0. While Reset is high, M_Stall=0 regardless of M_Req.
  - Reset mid-access aborts the access. No DM_WE pulse is produced in the reset cycle.
- States: IDLE, BUSY, DONE. There is an owner register: M or X.
- IDLE:
  - If M_Req: owner=M.
  - Else if X_Req: owner=X.
  - With a request, go to BUSY and load count=WAIT_CYCLES. If WAIT_CYCLES=0, go directly to DONE.
  - With no request, stay in IDLE.
  - Requester fields are latched on the grant edge. DM_* are driven from the latched fields while in BUSY/DONE.
- BUSY: count decrements each cycle. When count==1 (or on entry with count 0), the next state is DONE.
- DONE: a single cycle.
  - DM_WE = latched WE. This is the only cycle a write pulse can occur.
  - Read data is taken from dm_M RD. M_RD is a combinational pass-through of RD.
  - X read data is registered into X_RD at the end of the DONE cycle.
  - Next state is IDLE. Grant is re-evaluated in that IDLE cycle, giving a 1-cycle gap between accesses.
- M_Stall = M_Req & ~(state==DONE & owner==M).
  - Stall covers the IDLE-grant cycle, every BUSY cycle, and any cycle where X owns the port.
  - The M-stage access therefore completes in WAIT_CYCLES+2 cycles from request.
- X_Gnt = 1 in BUSY/DONE when owner=X. X_Done = 1 in DONE when owner=X.
- Abort:
  - If the owner's Req drops while in BUSY (e.g. an M flush), go to IDLE next cycle with no write pulse.
  - Req dropping in DONE has no effect; the write already commits.
- Simultaneous M_Req and X_Req in IDLE: M wins (fixed priority), unless the optional feature below is compiled in.
- Stores from M write using the M_LStype byte/half rules of dm_M. X is always word-type.

Optional Feature:
- Macro: DMARB_FAIR_EN.
- Defined: a last-owner flag alternates the grant when both requesters are pending in IDLE, so X is granted at least every second access under contention. The flag is reset to M, so X wins the first tie after reset.
- Undefined: strict M priority. X can starve while M requests back-to-back.

Decomposition:
- Add to macros.v: state encodings `dma_idle/`dma_busy/`dma_done, owner encodings `dma_own_m/`dma_own_x, and the word LStype constant.
- The wait counter is a natural sub-module, dma_wait_cnt (load, decrement, zero flag, width CNT_W).
- The FSM, arbitration and muxing stay in the top module.

Test Plan:
- Store, WAIT_CYCLES=2: M_Req=1, M_WE=1, Addr=0x10, WD=0xDEADBEEF → M_Stall high for 3 cycles, DM_WE high in exactly 1 cycle, mem[0x10]=0xDEADBEEF, M_Stall low in the DONE cycle.
- Load after store: M load 0x10 → M_RD=0xDEADBEEF in the DONE cycle, total 4 cycles from request.
- Contention without DMARB_FAIR_EN: M_Req and X_Req both high → M is served first, then after a 1-cycle IDLE X_Gnt rises; X_Done pulses once with X_RD = mem[X_Addr].
- Contention with DMARB_FAIR_EN and M requesting continuously: grants alternate X, M, X, M; each X_Done pulse follows every other completion.
- Abort: X store granted, X_Req dropped in BUSY → no DM_WE pulse, memory unchanged, state is IDLE next cycle.
- Reset in BUSY of an M store → DM_WE never asserts, M_Stall=0 during reset, and the next request completes normally. Repeat with WAIT_CYCLES=0: each access takes 2 cycles.

Source files
------------

// File: rtl/dm_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_arbiter_pkg
//  Description : Shared types and constants for the data-memory access
//                arbiter. It defines the sequencer state encoding, the
//                port-owner encoding and the word LStype code that is forced
//                for secondary-port accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_access_arbiter_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_BUSY = 2'd1,
        DMA_DONE = 2'd2
    } dma_state_e;

    typedef enum logic {
        DMA_OWN_M = 1'b0,
        DMA_OWN_X = 1'b1
    } dma_owner_e;

    // Word access code in the control-path LStype encoding.
    localparam logic [2:0] C_LS_WORD = 3'd0;

endpackage
`default_nettype wire

// File: rtl/dma_wait_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : dma_wait_cnt
//  Description : Loadable down-counter that times the wait states of one
//                memory access. A load has priority over a decrement, and the
//                counter saturates at zero.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_load          - load i_load_val this cycle
//                i_load_val      - value to load
//                i_dec           - decrement by one (ignored at zero)
//                o_count         - current count
//                o_zero          - count equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/dm_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_arbiter
//  Description : Shares the single data-memory port between the pipeline
//                M stage and a secondary requester X (loader/debug bridge).
//                Every access takes WAIT_CYCLES+1 cycles after the grant
//                cycle (IDLE -> BUSY... -> DONE). The write strobe to memory
//                is only raised in DONE. The M stage is stalled until its own
//                DONE cycle.
//  Build macro : DMARB_FAIR_EN - when defined, ties in IDLE alternate between
//                M and X (X wins the first tie after reset). When undefined,
//                M has strict priority.
//  Ports       : Clk, Reset                  - clock, sync active-high reset
//                M_Req/WE/Addr/WD/LStype     - M-stage request
//                M_RD, M_Stall               - M read data, pipeline freeze
//                X_Req/WE/Addr/WD            - secondary request (word only)
//                X_Gnt, X_Done, X_RD         - secondary grant/done/read data
//                DM_Addr/WD/WE/LStype        - to the data memory
//                DM_RD                       - read data from the data memory
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        M_Req,
    input  logic        M_WE,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WD,
    input  logic [2:0]  M_LStype,
    output logic [31:0] M_RD,
    output logic        M_Stall,
    input  logic        X_Req,
    input  logic        X_WE,
    input  logic [31:0] X_Addr,
    input  logic [31:0] X_WD,
    output logic        X_Gnt,
    output logic        X_Done,
    output logic [31:0] X_RD,
    output logic [31:0] DM_Addr,
    output logic [31:0] DM_WD,
    output logic        DM_WE,
    output logic [2:0]  DM_LStype,
    input  logic [31:0] DM_RD
);

    localparam logic [CNT_W-1:0] C_WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    dma_state_e  state_q,  state_d;
    dma_owner_e  owner_q,  owner_d;
    logic        we_q,     we_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wd_q,     wd_d;
    logic [2:0]  lstype_q, lstype_d;
    logic [31:0] xrd_q,    xrd_d;

    logic             w_pick_x;
    logic             w_owner_req;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;

    dma_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk        (Clk),
        .rst        (Reset),
        .i_load     (w_cnt_load),
        .i_load_val (C_WAIT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // Grant selection in IDLE. owner_q still holds the previous owner while
    // idle, so it doubles as the last-owner flag for the fair variant.
`ifdef DMARB_FAIR_EN
    assign w_pick_x = X_Req & (~M_Req | (owner_q == DMA_OWN_M));
`else
    assign w_pick_x = X_Req & ~M_Req;
`endif

    assign w_owner_req = (owner_q == DMA_OWN_X) ? X_Req : M_Req;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        lstype_d   = lstype_q;
        xrd_d      = xrd_q;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;

        case (state_q)
            DMA_IDLE: begin
                if (M_Req || X_Req) begin
                    w_cnt_load = 1'b1;
                    if (w_pick_x) begin
                        owner_d  = DMA_OWN_X;
                        we_d     = X_WE;
                        addr_d   = X_Addr;
                        wd_d     = X_WD;
                        lstype_d = C_LS_WORD;
                    end else begin
                        owner_d  = DMA_OWN_M;
                        we_d     = M_WE;
                        addr_d   = M_Addr;
                        wd_d     = M_WD;
                        lstype_d = M_LStype;
                    end
                    state_d = (WAIT_CYCLES == 0) ? DMA_DONE : DMA_BUSY;
                end
            end
            DMA_BUSY: begin
                w_cnt_dec = 1'b1;
                // Owner withdrew (e.g. flush): abandon before any write.
                if (!w_owner_req) begin
                    state_d = DMA_IDLE;
                end else if (w_cnt_zero || (w_cnt == CNT_W'(1))) begin
                    state_d = DMA_DONE;
                end
            end
            DMA_DONE: begin
                state_d = DMA_IDLE;
                if ((owner_q == DMA_OWN_X) && !we_q) begin
                    xrd_d = DM_RD;
                end
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= DMA_IDLE;
            owner_q  <= DMA_OWN_M;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            lstype_q <= C_LS_WORD;
            xrd_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            lstype_q <= lstype_d;
            xrd_q    <= xrd_d;
        end
    end

    // Outputs are gated by Reset so that a reset landing on a DONE cycle
    // can neither commit a write nor release/stall the pipeline.
    assign M_Stall   = M_Req & ~Reset &
                       ~((state_q == DMA_DONE) && (owner_q == DMA_OWN_M));
    assign M_RD      = DM_RD;
    assign X_Gnt     = ~Reset & (owner_q == DMA_OWN_X) &
                       ((state_q == DMA_BUSY) || (state_q == DMA_DONE));
    assign X_Done    = ~Reset & (owner_q == DMA_OWN_X) & (state_q == DMA_DONE);
    assign X_RD      = xrd_q;
    assign DM_WE     = ~Reset & we_q & (state_q == DMA_DONE);
    assign DM_Addr   = addr_q;
    assign DM_WD     = wd_q;
    assign DM_LStype = lstype_q;

endmodule
`default_nettype wire
